// File: rtl/lcd_frame_writer.sv
// HD44780-class LCD frame writer: init commands then N_CHARS data bytes, then oDONE.
// Optional feature macro: LCD_CURSOR_BLINK_EN (display-on command 8'h0F instead of 8'h0C).
`timescale 1ns/1ps
module lcd_frame_writer #(
  parameter int unsigned N_CHARS = 90,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [8*N_CHARS-1:0]   iDATA,
  output logic                   oDONE,
  output logic [7:0]             LCD_DATA,
  output logic                   LCD_RS,
  output logic                   LCD_RW,
  output logic                   LCD_EN
);

  localparam int unsigned FRAME_W = 8 * N_CHARS;
  localparam int unsigned T_MAX_A = (T_CLR > T_CMD) ? T_CLR : T_CMD;
  localparam int unsigned T_MAX_B = (T_EN > T_SETUP) ? T_EN : T_SETUP;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CNT_W   = $clog2(T_MAX + 1);
  localparam int unsigned STEP_W  = $clog2(N_CHARS + 5);
  localparam int unsigned N_CMDS  = 5;

`ifdef LCD_CURSOR_BLINK_EN
  localparam logic [7:0] CMD_DISPLAY = 8'h0F;
`else
  localparam logic [7:0] CMD_DISPLAY = 8'h0C;
`endif

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_e;
  typedef enum logic [1:0] {P_SETUP, P_STROBE, P_HOLD} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [7:0]          data_q, data_d;
  logic                rs_q, rs_d;
  logic                en_q, en_d;
  logic                done_q, done_d;
  int unsigned         hold_len;

  // Next-state and next-output computation; bus outputs follow the next step.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    frame_d  = frame_q;
    data_d   = data_q;
    rs_d     = rs_q;
    en_d     = 1'b0;
    done_d   = done_q;
    hold_len = (step_q == STEP_W'(2)) ? T_CLR : T_CMD;

    case (state_q)
      S_IDLE: begin
        state_d = S_XFER;
        phase_d = P_SETUP;
        cnt_d   = '0;
        step_d  = '0;
        frame_d = iDATA;
        done_d  = 1'b0;
      end
      S_XFER: begin
        case (phase_q)
          P_SETUP: begin
            if (cnt_q == CNT_W'(T_SETUP - 1)) begin
              phase_d = P_STROBE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          P_STROBE: begin
            if (cnt_q == CNT_W'(T_EN - 1)) begin
              phase_d = P_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          P_HOLD: begin
            if (cnt_q == CNT_W'(hold_len - 1)) begin
              cnt_d = '0;
              if (step_q == STEP_W'(N_CHARS + N_CMDS - 1)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                step_d  = step_q + STEP_W'(1);
                phase_d = P_SETUP;
                // Frame is consumed MSB-first; shift once per finished character.
                if (step_q >= STEP_W'(N_CMDS)) frame_d = frame_q << 8;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: phase_d = P_SETUP;
        endcase
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_XFER) begin
      en_d = (phase_d == P_STROBE);
      rs_d = (step_d >= STEP_W'(N_CMDS));
      case (step_d)
        STEP_W'(0): data_d = 8'h38;
        STEP_W'(1): data_d = CMD_DISPLAY;
        STEP_W'(2): data_d = 8'h01;
        STEP_W'(3): data_d = 8'h06;
        STEP_W'(4): data_d = 8'h80;
        default:    data_d = frame_d[FRAME_W-1 -: 8];
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      phase_q <= P_SETUP;
      cnt_q   <= '0;
      step_q  <= '0;
      frame_q <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign oDONE    = done_q;
  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer using scaled-down timing parameters.
`timescale 1ns/1ps
module tb_lcd_frame_writer;

  localparam int unsigned N   = 8;
  localparam int unsigned TS  = 4;
  localparam int unsigned TE  = 5;
  localparam int unsigned TC  = 20;
  localparam int unsigned TCL = 60;
  localparam int unsigned NP  = N + 5;
  // 1 + 13*(4+5) + 12*20 + 60 = 418
  localparam int          LAT = 418;

`ifdef LCD_CURSOR_BLINK_EN
  localparam logic [7:0] CMD1 = 8'h0F;
`else
  localparam logic [7:0] CMD1 = 8'h0C;
`endif

  localparam logic [8*N-1:0] FRAME_A = "PILOUTAB";
  localparam logic [8*N-1:0] FRAME_B = "NEWFRAME";
  localparam logic [7:0] CHARS_A [N] = '{8'h50, 8'h49, 8'h4C, 8'h4F, 8'h55, 8'h54, 8'h41, 8'h42};
  localparam logic [7:0] CHARS_B [N] = '{8'h4E, 8'h45, 8'h57, 8'h46, 8'h52, 8'h41, 8'h4D, 8'h45};

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] idata;
  logic           done;
  logic [7:0]     lcd_data;
  logic           lcd_rs, lcd_rw, lcd_en;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  lcd_frame_writer #(
    .N_CHARS (N),
    .T_SETUP (TS),
    .T_EN    (TE),
    .T_CMD   (TC),
    .T_CLR   (TCL)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iDATA    (idata),
    .oDONE    (done),
    .LCD_DATA (lcd_data),
    .LCD_RS   (lcd_rs),
    .LCD_RW   (lcd_rw),
    .LCD_EN   (lcd_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Enable-pulse monitor
  logic       mon_clr = 1'b1;
  int         np = 0;
  logic       en_prev = 1'b0;
  logic       unstable = 1'b0;
  logic       rw_bad = 1'b0;
  int         rise_c = 0;
  int         fall_c = 0;
  logic [7:0] p_data [32];
  logic       p_rs   [32];
  int         p_w    [32];
  int         p_gap  [32];

  always @(negedge clk) begin
    if (mon_clr) begin
      np = 0; en_prev = 1'b0; unstable = 1'b0; rw_bad = 1'b0;
    end else begin
      if (lcd_rw !== 1'b0) rw_bad = 1'b1;
      if (lcd_en === 1'b1 && !en_prev) begin
        if (np < 32) begin
          p_data[np] = lcd_data; p_rs[np] = lcd_rs; p_gap[np] = cyc - fall_c;
        end
        rise_c = cyc;
      end else if (lcd_en === 1'b1 && np < 32) begin
        if (lcd_data !== p_data[np] || lcd_rs !== p_rs[np]) unstable = 1'b1;
      end
      if (lcd_en !== 1'b1 && en_prev) begin
        if (np < 32) p_w[np] = cyc - rise_c;
        np++;
        fall_c = cyc;
      end
      en_prev = (lcd_en === 1'b1);
    end
  end

  function automatic logic [7:0] exp_byte(input int i, input bit second);
    case (i)
      0: exp_byte = 8'h38;
      1: exp_byte = CMD1;
      2: exp_byte = 8'h01;
      3: exp_byte = 8'h06;
      4: exp_byte = 8'h80;
      default: exp_byte = second ? CHARS_B[i-5] : CHARS_A[i-5];
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick(2);
    mon_clr = 1'b0;
  endtask

  // Releases reset and waits for oDONE; optionally changes iDATA mid-frame.
  task automatic release_and_wait(input bit change_mid, output int lat);
    int rel;
    bit seen;
    seen = 1'b0;
    rst = 1'b0;
    rel = cyc;
    for (int i = 0; i < LAT + 100; i++) begin
      @(negedge clk);
      if (change_mid && np >= 8) idata = FRAME_B;
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    lat = cyc - rel;
    n_chk++;
    if (!seen) $display("FAIL done_timeout: oDONE=%b after %0d cycles, required 1", done, lat);
    else n_pass++;
  endtask

  task automatic check_sequence(input string tag, input bit second, input int lat);
    int exp_gap;
    n_chk++;
    if (lat < LAT - 2 || lat > LAT + 2)
      $display("FAIL %s latency: got %0d cycles, required %0d+-2", tag, lat, LAT);
    else n_pass++;
    n_chk++;
    if (np !== NP) $display("FAIL %s pulse_count: got %0d, required %0d", tag, np, NP);
    else n_pass++;
    for (int i = 0; i < NP && i < np; i++) begin
      n_chk++;
      if (p_data[i] !== exp_byte(i, second))
        $display("FAIL %s data[%0d]: got %h, required %h", tag, i, p_data[i], exp_byte(i, second));
      else n_pass++;
      n_chk++;
      if (p_rs[i] !== (i >= 5))
        $display("FAIL %s rs[%0d]: got %b, required %b", tag, i, p_rs[i], (i >= 5));
      else n_pass++;
      n_chk++;
      if (p_w[i] !== TE) $display("FAIL %s en_width[%0d]: got %0d, required %0d", tag, i, p_w[i], TE);
      else n_pass++;
      if (i > 0) begin
        exp_gap = (i == 3) ? TCL + TS : TC + TS;
        n_chk++;
        if (p_gap[i] !== exp_gap)
          $display("FAIL %s gap[%0d]: got %0d, required %0d", tag, i, p_gap[i], exp_gap);
        else n_pass++;
      end
    end
    n_chk++;
    if (unstable !== 1'b0) $display("FAIL %s bus_stable: unstable=%b, required 0", tag, unstable);
    else n_pass++;
    n_chk++;
    if (rw_bad !== 1'b0) $display("FAIL %s rw_zero: rw_bad=%b, required 0", tag, rw_bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idata = FRAME_A;
    tick(10);
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done); else n_pass++;
    n_chk++; if (lcd_en !== 1'b0) $display("FAIL reset_en: got %b, required 0", lcd_en); else n_pass++;
    n_chk++; if (lcd_data !== 8'h00) $display("FAIL reset_data: got %h, required 00", lcd_data); else n_pass++;
    n_chk++; if (lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b, required 0", lcd_rs); else n_pass++;
    n_chk++; if (lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b, required 0", lcd_rw); else n_pass++;
  endtask

  task automatic test_frame();
    int lat;
    rst = 1'b1;
    idata = FRAME_A;
    clear_mon();
    release_and_wait(1'b0, lat);
    check_sequence("frame", 1'b0, lat);
    tick(30);
    n_chk++; if (done !== 1'b1) $display("FAIL done_hold: got %b, required 1", done); else n_pass++;
    n_chk++; if (np !== NP) $display("FAIL no_refresh: pulses %0d, required %0d", np, NP); else n_pass++;
    n_chk++; if (lcd_data !== 8'h42) $display("FAIL bus_hold_data: got %h, required 42", lcd_data); else n_pass++;
    n_chk++; if (lcd_rs !== 1'b1) $display("FAIL bus_hold_rs: got %b, required 1", lcd_rs); else n_pass++;
  endtask

  task automatic test_snapshot();
    int lat;
    rst = 1'b1;
    idata = FRAME_A;
    tick(3);
    clear_mon();
    release_and_wait(1'b1, lat);
    check_sequence("snapshot", 1'b0, lat);
  endtask

  task automatic test_abort();
    int lat;
    bit hit;
    hit = 1'b0;
    rst = 1'b1;
    idata = FRAME_A;
    tick(3);
    clear_mon();
    rst = 1'b0;
    for (int i = 0; i < LAT + 100; i++) begin
      @(negedge clk);
      if (np == 9 && lcd_en === 1'b1) begin hit = 1'b1; break; end
    end
    n_chk++;
    if (!hit) $display("FAIL abort_reach: strobe of char 4 seen=%b, required 1", hit); else n_pass++;
    rst = 1'b1;
    tick(1);
    n_chk++; if (lcd_en !== 1'b0) $display("FAIL abort_en: got %b, required 0", lcd_en); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL abort_done: got %b, required 0", done); else n_pass++;
    n_chk++; if (lcd_data !== 8'h00) $display("FAIL abort_data: got %h, required 00", lcd_data); else n_pass++;
    tick(3);
    idata = FRAME_B;
    clear_mon();
    release_and_wait(1'b0, lat);
    check_sequence("restart", 1'b1, lat);
  endtask

  initial begin
    rst = 1'b1;
    idata = FRAME_A;
    test_reset();
    test_frame();
    test_snapshot();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
